// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes and datapath mux selects.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      MEM_ADDR = 4'd4,
      MEM_RD   = 4'd5,
      MEM_WR   = 4'd6,
      WB_R     = 4'd7,
      WB_I     = 4'd8,
      WB_MEM   = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      PERF     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_PERF  = 6'b110011;

   localparam logic [1:0] PC_SRC_ALU     = 2'b00;
   localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;

   localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
   localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
   localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_SLT   = 2'b11;

   // States whose exit back to FETCH completes an instruction.
   function automatic logic is_final(input state_t s);
      return (s == WB_R) || (s == WB_I) || (s == WB_MEM) || (s == MEM_WR) ||
             (s == BRANCH) || (s == JUMP) || (s == PERF);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Opcode dispatch used in DECODE. MCTRL_PERF_EN enables the PERF opcode;
// otherwise it falls through to the R-type path like any unknown opcode.
module mctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output state_t     next_state
);

   always_comb begin
      next_state = EXEC_R;
      case (opcode)
         OP_RTYPE:         next_state = EXEC_R;
         OP_ADDI, OP_SLTI: next_state = EXEC_I;
         OP_LW, OP_SW:     next_state = MEM_ADDR;
         OP_BEQ:           next_state = BRANCH;
         OP_J, OP_JAL:     next_state = JUMP;
`ifdef MCTRL_PERF_EN
         OP_PERF:          next_state = PERF;
`endif
         default:          next_state = EXEC_R;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM. Define MCTRL_PERF_EN to add the PERF
// instruction and the instr_retired counter.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_write,
   output logic        i_or_d,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic        perf,
   output logic        sign_or_zero,
   output logic [1:0]  pc_src,
   output logic [1:0]  reg_dst,
   output logic [1:0]  mem_to_reg,
   output logic [1:0]  alu_op,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  state
`ifdef MCTRL_PERF_EN
   ,
   output logic [31:0] instr_retired
`endif
);

   state_t state_reg;
   state_t state_next;
   state_t state_cur;
   state_t decode_next;

   mctrl_decode u_decode (
      .opcode     (opcode),
      .next_state (decode_next)
   );

   // Reset presents FETCH outputs immediately, before the register has cleared.
   assign state_cur = reset ? FETCH : state_reg;
   assign state     = state_cur;

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= FETCH;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next   = state_reg;
      mem_req      = 1'b0;
      mem_write    = 1'b0;
      i_or_d       = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      perf         = 1'b0;
      sign_or_zero = 1'b1;
      pc_src       = PC_SRC_ALU;
      reg_dst      = REG_DST_RT;
      mem_to_reg   = MEM_TO_REG_ALU;
      alu_op       = ALU_OP_ADD;
      alu_src_b    = 2'b00;

      case (state_cur)
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ack) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            alu_src_b  = 2'b11;
            state_next = decode_next;
         end
         EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_OP_FUNCT;
            state_next = WB_R;
         end
         EXEC_I: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'b10;
            alu_op       = (opcode == OP_SLTI) ? ALU_OP_SLT : ALU_OP_ADD;
            sign_or_zero = (opcode != OP_SLTI);
            state_next   = WB_I;
         end
         MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ack)
               state_next = WB_MEM;
         end
         MEM_WR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ack)
               state_next = FETCH;
         end
         WB_R: begin
            reg_dst    = REG_DST_RD;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         WB_I: begin
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         WB_MEM: begin
            mem_to_reg = MEM_TO_REG_MEM;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            alu_op     = ALU_OP_SUB;
            pc_src     = PC_SRC_ALU_OUT;
            pc_write   = zero;
            state_next = FETCH;
         end
         JUMP: begin
            pc_src   = PC_SRC_JUMP;
            pc_write = 1'b1;
            if (opcode == OP_JAL) begin
               reg_dst    = REG_DST_RA;
               mem_to_reg = MEM_TO_REG_PC;
               reg_write  = 1'b1;
            end
            state_next = FETCH;
         end
         PERF: begin
`ifdef MCTRL_PERF_EN
            perf = 1'b1;
`endif
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase

      // Side-effecting strobes must never fire while reset is held.
      if (reset) begin
         mem_req    = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         reg_write  = 1'b0;
         perf       = 1'b0;
         state_next = FETCH;
      end
   end

`ifdef MCTRL_PERF_EN
   logic [31:0] instr_retired_reg;

   always_ff @(posedge clk) begin
      if (reset)
         instr_retired_reg <= 32'd0;
      else if (is_final(state_reg) && (state_next == FETCH))
         instr_retired_reg <= instr_retired_reg + 32'd1;
   end

   assign instr_retired = instr_retired_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; follows MCTRL_PERF_EN to pick the PERF or R-type expectations.
module tb_multicycle_ctrl;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC_R = 4'd2;
   localparam logic [3:0] S_EXEC_I = 4'd3;
   localparam logic [3:0] S_MADDR  = 4'd4;
   localparam logic [3:0] S_MEM_RD = 4'd5;
   localparam logic [3:0] S_MEM_WR = 4'd6;
   localparam logic [3:0] S_WB_R   = 4'd7;
   localparam logic [3:0] S_WB_I   = 4'd8;
   localparam logic [3:0] S_WB_MEM = 4'd9;
   localparam logic [3:0] S_BRANCH = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_PERF   = 4'd12;

   logic        clk = 1'b0;
   logic        reset, zero, mem_ack;
   logic [5:0]  opcode;
   logic        mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write;
   logic        alu_src_a, perf, sign_or_zero;
   logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_op, alu_src_b;
   logic [3:0]  state;
`ifdef MCTRL_PERF_EN
   logic [31:0] instr_retired;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   multicycle_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .zero         (zero),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_write    (mem_write),
      .i_or_d       (i_or_d),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .reg_write    (reg_write),
      .alu_src_a    (alu_src_a),
      .perf         (perf),
      .sign_or_zero (sign_or_zero),
      .pc_src       (pc_src),
      .reg_dst      (reg_dst),
      .mem_to_reg   (mem_to_reg),
      .alu_op       (alu_op),
      .alu_src_b    (alu_src_b),
      .state        (state)
`ifdef MCTRL_PERF_EN
      ,
      .instr_retired(instr_retired)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One FETCH cycle with an immediate ack; leaves the bench in DECODE.
   task automatic do_fetch(input string tag);
      mem_ack = 1'b1;
      #1;
      check_val({tag, ".fetch.state"}, 32'(state), 32'(S_FETCH));
      check_val({tag, ".fetch.req"}, 32'(mem_req), 32'd1);
      check_val({tag, ".fetch.iord"}, 32'(i_or_d), 32'd0);
      check_val({tag, ".fetch.irw"}, 32'(ir_write), 32'd1);
      check_val({tag, ".fetch.pcw"}, 32'(pc_write), 32'd1);
      check_val({tag, ".fetch.srcb"}, 32'(alu_src_b), 32'd1);
      tick();
      #1;
      check_val({tag, ".dec.state"}, 32'(state), 32'(S_DECODE));
      check_val({tag, ".dec.srcb"}, 32'(alu_src_b), 32'd3);
      tick();
   endtask

   task automatic do_addi(input string tag);
      opcode = 6'b001000;
      do_fetch(tag);
      #1;
      check_val({tag, ".exec.state"}, 32'(state), 32'(S_EXEC_I));
      check_val({tag, ".exec.aluop"}, 32'(alu_op), 32'd0);
      check_val({tag, ".exec.soz"}, 32'(sign_or_zero), 32'd1);
      tick();
      #1;
      check_val({tag, ".wb.state"}, 32'(state), 32'(S_WB_I));
      check_val({tag, ".wb.regw"}, 32'(reg_write), 32'd1);
      tick();
      $display("txn %s addi done", tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ack = 1'b0;
      repeat (2) tick();
      mem_ack = 1'b1;
      #1;
      check_val("rst.state", 32'(state), 32'(S_FETCH));
      check_val("rst.req", 32'(mem_req), 32'd0);
      check_val("rst.irw", 32'(ir_write), 32'd0);
      check_val("rst.pcw", 32'(pc_write), 32'd0);
      check_val("rst.srcb", 32'(alu_src_b), 32'd1);
      check_val("rst.soz", 32'(sign_or_zero), 32'd1);
`ifdef MCTRL_PERF_EN
      check_val("rst.retired", instr_retired, 32'd0);
`endif
      mem_ack = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      check_val("rst.first_req", 32'(mem_req), 32'd1);
      $display("txn reset done");

      // R-type with mem_ack high every cycle
      opcode = 6'b000000;
      do_fetch("r");
      #1;
      check_val("r.exec.state", 32'(state), 32'(S_EXEC_R));
      check_val("r.exec.srca", 32'(alu_src_a), 32'd1);
      check_val("r.exec.aluop", 32'(alu_op), 32'd2);
      check_val("r.exec.regw", 32'(reg_write), 32'd0);
      opcode = 6'b100011;
      tick();
      #1;
      check_val("r.wb.state", 32'(state), 32'(S_WB_R));
      check_val("r.wb.regw", 32'(reg_write), 32'd1);
      check_val("r.wb.regdst", 32'(reg_dst), 32'd1);
      tick();
      #1;
      check_val("r.done.state", 32'(state), 32'(S_FETCH));
      $display("txn r-type done");

      do_addi("a1");

      opcode = 6'b001010;
      do_fetch("slti");
      #1;
      check_val("slti.exec.aluop", 32'(alu_op), 32'd3);
      check_val("slti.exec.soz", 32'(sign_or_zero), 32'd0);
      tick();
      #1;
      check_val("slti.wb.state", 32'(state), 32'(S_WB_I));
      tick();
      $display("txn slti done");

      // lw with mem_ack withheld for three MEM_RD cycles
      opcode = 6'b100011;
      do_fetch("lw");
      #1;
      check_val("lw.addr.state", 32'(state), 32'(S_MADDR));
      check_val("lw.addr.srcb", 32'(alu_src_b), 32'd2);
      tick();
      for (int i = 0; i < 4; i++) begin
         mem_ack = (i == 3);
         #1;
         check_val("lw.rd.state", 32'(state), 32'(S_MEM_RD));
         check_val("lw.rd.req", 32'(mem_req), 32'd1);
         check_val("lw.rd.iord", 32'(i_or_d), 32'd1);
         check_val("lw.rd.memw", 32'(mem_write), 32'd0);
         tick();
      end
      #1;
      check_val("lw.wb.state", 32'(state), 32'(S_WB_MEM));
      check_val("lw.wb.m2r", 32'(mem_to_reg), 32'd1);
      check_val("lw.wb.regw", 32'(reg_write), 32'd1);
      check_val("lw.wb.req", 32'(mem_req), 32'd0);
      tick();
      $display("txn lw done");

      for (int z = 1; z >= 0; z--) begin
         opcode = 6'b000100;
         zero = z[0];
         do_fetch("beq");
         #1;
         check_val("beq.state", 32'(state), 32'(S_BRANCH));
         check_val("beq.pcw", 32'(pc_write), 32'(z));
         check_val("beq.pcsrc", 32'(pc_src), 32'd1);
         check_val("beq.aluop", 32'(alu_op), 32'd1);
         tick();
         $display("txn beq zero=%0d done", z);
      end
      zero = 1'b0;

      opcode = 6'b000011;
      do_fetch("jal");
      #1;
      check_val("jal.state", 32'(state), 32'(S_JUMP));
      check_val("jal.pcsrc", 32'(pc_src), 32'd2);
      check_val("jal.regdst", 32'(reg_dst), 32'd2);
      check_val("jal.m2r", 32'(mem_to_reg), 32'd2);
      check_val("jal.regw", 32'(reg_write), 32'd1);
      check_val("jal.pcw", 32'(pc_write), 32'd1);
      tick();
      $display("txn jal done");

      // sw interrupted by reset while the store request is outstanding
      opcode = 6'b101011;
      do_fetch("sw");
      tick();
      mem_ack = 1'b0;
      #1;
      check_val("sw.wr.state", 32'(state), 32'(S_MEM_WR));
      check_val("sw.wr.req", 32'(mem_req), 32'd1);
      check_val("sw.wr.memw", 32'(mem_write), 32'd1);
      reset = 1'b1;
      #1;
      check_val("sw.rst.req", 32'(mem_req), 32'd0);
      check_val("sw.rst.memw", 32'(mem_write), 32'd0);
      tick();
      #1;
      check_val("sw.rst.state", 32'(state), 32'(S_FETCH));
      check_val("sw.rst.memw2", 32'(mem_write), 32'd0);
      reset = 1'b0;
      #1;
      check_val("sw.after.req", 32'(mem_req), 32'd1);
      check_val("sw.after.iord", 32'(i_or_d), 32'd0);
      check_val("sw.after.memw", 32'(mem_write), 32'd0);
      $display("txn sw-reset done");

      do_addi("a2");
      opcode = 6'b110011;
      do_fetch("perf");
      #1;
`ifdef MCTRL_PERF_EN
      check_val("perf.state", 32'(state), 32'(S_PERF));
      check_val("perf.pulse", 32'(perf), 32'd1);
      tick();
      #1;
      check_val("perf.after", 32'(perf), 32'd0);
      check_val("perf.retired", instr_retired, 32'd2);
`else
      check_val("perf.rtype.state", 32'(state), 32'(S_EXEC_R));
      check_val("perf.rtype.pulse", 32'(perf), 32'd0);
      tick();
      #1;
      check_val("perf.rtype.wb", 32'(state), 32'(S_WB_R));
      check_val("perf.rtype.regw", 32'(reg_write), 32'd1);
      tick();
`endif
      $display("txn perf-opcode done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
